// File: rtl/fb_write_scheduler_pkg.sv
// Shared types for the frame-buffer write side: pixel format, scheduler states, frame size helper.
package fb_pkg;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CLEAR      = 3'd1,
        DRAW       = 3'd2,
        WAIT_VSYNC = 3'd3,
        SWAP       = 3'd4
    } fb_sched_state_t;

    function automatic int fb_pixels(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/fb_write_scheduler_if.sv
// Frame control, renderer request and frame-buffer write signals of fb_write_scheduler.
// Statistics outputs exist only when FB_WR_STATS_EN is defined.
interface fb_write_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int FB_SIZE = 16
);
    logic                      frame_start_in;
    logic [15:0]               clear_color_in;
    logic                      frame_done_in;
    logic                      vsync_in;
    logic [NUM_REQ-1:0]        req_valid_in;
    logic [NUM_REQ*FB_SIZE-1:0] req_addr_in;
    logic [NUM_REQ*16-1:0]     req_data_in;
    logic [NUM_REQ-1:0]        req_ready_out;
    logic [FB_SIZE-1:0]        write_addr_out;
    logic [15:0]               write_data_out;
    logic                      write_enable_out;
    logic                      swap_buffer_out;
    logic                      busy_out;
`ifdef FB_WR_STATS_EN
    logic [31:0]               pix_written_out;
    logic [15:0]               pix_dropped_out;
    logic [31:0]               stall_cycles_out;
`endif

    modport master (
        output frame_start_in, clear_color_in, frame_done_in, vsync_in,
               req_valid_in, req_addr_in, req_data_in,
        input  req_ready_out, write_addr_out, write_data_out, write_enable_out,
               swap_buffer_out, busy_out
`ifdef FB_WR_STATS_EN
        , input pix_written_out, pix_dropped_out, stall_cycles_out
`endif
    );

    modport slave (
        input  frame_start_in, clear_color_in, frame_done_in, vsync_in,
               req_valid_in, req_addr_in, req_data_in,
        output req_ready_out, write_addr_out, write_data_out, write_enable_out,
               swap_buffer_out, busy_out
`ifdef FB_WR_STATS_EN
        , output pix_written_out, pix_dropped_out, stall_cycles_out
`endif
    );
endinterface

// File: rtl/fb_write_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from a pointer,
// pointer moves past the winner whenever advance is high and something was granted.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);
    logic [IW-1:0] ptr;
    logic          found;
    int            j;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                index    = IW'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (advance && found)
            ptr <= (int'(index) == N - 1) ? '0 : index + IW'(1);
    end
endmodule

// File: rtl/fb_write_scheduler.sv
// Per-frame write sequencer: clear back buffer, arbitrate renderer writes, swap at vsync.
// Optional statistics counters are compiled in with FB_WR_STATS_EN.
module fb_write_scheduler
    import fb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 180
) (
    input  logic clk_in,
    input  logic rst_in,
    fb_write_scheduler_if.slave bus
);
    localparam int PIX     = fb_pixels(FB_WIDTH, FB_HEIGHT);
    localparam int FB_SIZE = $clog2(PIX);
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_CLEAR = CLEAR;
    localparam logic [2:0] S_DRAW  = DRAW;
    localparam logic [2:0] S_WAIT  = WAIT_VSYNC;
    localparam logic [2:0] S_SWAP  = SWAP;
    localparam logic [FB_SIZE-1:0] LAST_ADDR = FB_SIZE'(PIX - 1);

    logic [2:0]         state;
    logic [FB_SIZE-1:0] cnt;
    rgb565_t            color;
    logic               draw_en;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      gidx;
    logic               xfer;
    logic [FB_SIZE-1:0] sel_addr;
    rgb565_t            sel_data;
    logic               in_range;

    // frame_done closes the grant window in the same cycle it arrives
    assign draw_en = (state == S_DRAW) && !bus.frame_done_in;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk_in),
        .rst     (rst_in),
        .req     (bus.req_valid_in & {NUM_REQ{draw_en}}),
        .advance (draw_en),
        .grant   (grant),
        .index   (gidx)
    );

    assign bus.req_ready_out = grant;
    assign xfer     = |grant;
    assign sel_addr = bus.req_addr_in[int'(gidx)*FB_SIZE +: FB_SIZE];
    assign sel_data = bus.req_data_in[int'(gidx)*16 +: 16];
    assign in_range = int'(sel_addr) < PIX;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state                <= S_IDLE;
            cnt                  <= '0;
            color                <= '0;
            bus.write_addr_out   <= '0;
            bus.write_data_out   <= '0;
            bus.write_enable_out <= 1'b0;
            bus.swap_buffer_out  <= 1'b0;
            bus.busy_out         <= 1'b0;
        end else begin
            bus.write_enable_out <= 1'b0;
            bus.swap_buffer_out  <= 1'b0;
            case (state)
                S_IDLE: if (bus.frame_start_in) begin
                    state        <= S_CLEAR;
                    color        <= bus.clear_color_in;
                    cnt          <= '0;
                    bus.busy_out <= 1'b1;
                end
                S_CLEAR: begin
                    bus.write_enable_out <= 1'b1;
                    bus.write_addr_out   <= cnt;
                    bus.write_data_out   <= color;
                    if (cnt == LAST_ADDR) state <= S_DRAW;
                    else                  cnt   <= cnt + FB_SIZE'(1);
                end
                S_DRAW: begin
                    if (bus.frame_done_in) state <= S_WAIT;
                    if (xfer) begin
                        bus.write_enable_out <= in_range;
                        bus.write_addr_out   <= sel_addr;
                        bus.write_data_out   <= sel_data;
                    end
                end
                S_WAIT: if (bus.vsync_in) begin
                    state               <= S_SWAP;
                    bus.swap_buffer_out <= 1'b1;
                end
                S_SWAP: begin
                    state        <= S_IDLE;
                    bus.busy_out <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FB_WR_STATS_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bus.pix_written_out  <= '0;
            bus.pix_dropped_out  <= '0;
            bus.stall_cycles_out <= '0;
        end else if (state == S_IDLE && bus.frame_start_in) begin
            bus.pix_written_out  <= '0;
            bus.pix_dropped_out  <= '0;
            bus.stall_cycles_out <= '0;
        end else if (draw_en) begin
            if (xfer && in_range)
                bus.pix_written_out <= bus.pix_written_out + 32'd1;
            if (xfer && !in_range && bus.pix_dropped_out != 16'hFFFF)
                bus.pix_dropped_out <= bus.pix_dropped_out + 16'd1;
            if (|bus.req_valid_in && !xfer)
                bus.stall_cycles_out <= bus.stall_cycles_out + 32'd1;
        end
    end
`endif
endmodule
